// File: rtl/mac_operand_feeder.sv
`default_nettype none
// ============================================================================
// Module   : mac_operand_feeder
// Purpose  : Buffers signed int4/int8 operand pairs in a small FIFO and feeds
//            them to a MAC one pair per cycle during a dot-product run of
//            k_len pairs, with a registered advance strobe and done flag.
// Ports    : clk, reset (async, active-high)
//            s_valid/s_ready/s_a/s_b : upstream operand push interface
//            start/k_len             : run request and pair count
//            busy/done/count         : run status
//            pulse/out_a/out_b       : registered MAC operand outputs
// Config   : MAC_FEEDER_ZERO_SKIP_EN - pairs with a zero operand are consumed
//            and counted but produce no pulse and leave out_a/out_b unchanged.
// Revision : 1.0 - initial release
// ============================================================================
module mac_operand_feeder #(
  parameter int DEPTH = 4,
  parameter int KW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [3:0]    s_a,
  input  logic [7:0]    s_b,
  input  logic          start,
  input  logic [KW-1:0] k_len,
  output logic          busy,
  output logic          pulse,
  output logic [3:0]    out_a,
  output logic [7:0]    out_b,
  output logic          done,
  output logic [KW-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic [KW-1:0] k_lat_q, k_lat_d;
  logic [KW-1:0] count_q, count_d;
  logic          pulse_q, pulse_d;
  logic [3:0]    out_a_q, out_a_d;
  logic [7:0]    out_b_q, out_b_d;

  logic [3:0]    mem_a [DEPTH];
  logic [7:0]    mem_b [DEPTH];

  logic          full, empty, push, pop, skip;
  logic [3:0]    head_a;
  logic [7:0]    head_b;

  assign full   = (occ_q == C_DEPTH);
  assign empty  = (occ_q == '0);
  // Ready comes from the pre-edge full flag, so a pop never frees a slot
  // for a push on the same edge.
  assign push   = s_valid && !full;
  assign pop    = (state_q == RUN) && !empty;
  assign head_a = mem_a[rd_ptr_q];
  assign head_b = mem_b[rd_ptr_q];

`ifdef MAC_FEEDER_ZERO_SKIP_EN
  assign skip = (head_a == 4'd0) || (head_b == 8'd0);
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    k_lat_d  = k_lat_q;
    count_d  = count_q;
    pulse_d  = 1'b0;
    out_a_d  = out_a_q;
    out_b_d  = out_b_q;

    // DEPTH is a power of two, so the pointers wrap naturally.
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase

    case (state_q)
      IDLE: begin
        if (start) begin
          k_lat_d = k_len;
          count_d = '0;
          state_d = (k_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (pop) begin
          count_d = count_q + KW'(1);
          if (!skip) begin
            pulse_d = 1'b1;
            out_a_d = head_a;
            out_b_d = head_b;
          end
          if (count_q + KW'(1) == k_lat_q) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      k_lat_q  <= '0;
      count_q  <= '0;
      pulse_q  <= 1'b0;
      out_a_q  <= '0;
      out_b_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      k_lat_q  <= k_lat_d;
      count_q  <= count_d;
      pulse_q  <= pulse_d;
      out_a_q  <= out_a_d;
      out_b_q  <= out_b_d;
    end
  end

  // Storage needs no reset: the occupancy counter defines what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr_q] <= s_a;
      mem_b[wr_ptr_q] <= s_b;
    end
  end

  assign s_ready = !full;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign pulse   = pulse_q;
  assign out_a   = out_a_q;
  assign out_b   = out_b_q;
  assign count   = count_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_operand_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_operand_feeder
// Purpose  : Self-checking bench for mac_operand_feeder. A queue-based model
//            predicts every output each cycle; directed scenarios add literal
//            expectations, followed by a randomized phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_operand_feeder;

  localparam int DEPTH = 4;
  localparam int KW    = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          s_valid;
  logic          s_ready;
  logic [3:0]    s_a;
  logic [7:0]    s_b;
  logic          start;
  logic [KW-1:0] k_len;
  logic          busy;
  logic          pulse;
  logic [3:0]    out_a;
  logic [7:0]    out_b;
  logic          done;
  logic [KW-1:0] count;

  int tests = 0;
  int fails = 0;

  mac_operand_feeder #(.DEPTH(DEPTH), .KW(KW)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .start(start), .k_len(k_len),
    .busy(busy), .pulse(pulse), .out_a(out_a), .out_b(out_b),
    .done(done), .count(count)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [3:0]    q_a [$];
  logic [7:0]    q_b [$];
  bit            m_in_run;
  bit            m_done;
  int            m_left;
  logic [KW-1:0] m_count;
  bit            m_pulse;
  logic [3:0]    m_out_a;
  logic [7:0]    m_out_b;

  function automatic bit is_skipped(input logic [3:0] a, input logic [7:0] b);
`ifdef MAC_FEEDER_ZERO_SKIP_EN
    return (a == 4'd0) || (b == 8'd0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    q_a.delete(); q_b.delete();
    m_in_run = 0; m_done = 0; m_left = 0;
    m_count = '0; m_pulse = 0; m_out_a = '0; m_out_b = '0;
  endtask

  // Predicts the state after the coming rising edge from the current inputs.
  task automatic model_step();
    bit pushing;
    logic [3:0] pa;
    logic [7:0] pb;
    pushing = s_valid && (q_a.size() != DEPTH);
    m_pulse = 0;
    if (m_done) begin
      m_done = 0;
    end else if (!m_in_run) begin
      if (start) begin
        m_count = '0;
        if (k_len == '0) m_done = 1;
        else begin m_in_run = 1; m_left = int'(k_len); end
      end
    end else if (q_a.size() > 0) begin
      pa = q_a.pop_front();
      pb = q_b.pop_front();
      m_count = m_count + 1'b1;
      if (!is_skipped(pa, pb)) begin
        m_pulse = 1; m_out_a = pa; m_out_b = pb;
      end
      m_left--;
      if (m_left == 0) begin m_in_run = 0; m_done = 1; end
    end
    if (pushing) begin q_a.push_back(s_a); q_b.push_back(s_b); end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("s_ready", 32'(s_ready), 32'(q_a.size() != DEPTH));
    check("busy",    32'(busy),    32'(m_in_run || m_done));
    check("done",    32'(done),    32'(m_done));
    check("pulse",   32'(pulse),   32'(m_pulse));
    check("out_a",   32'(out_a),   32'(m_out_a));
    check("out_b",   32'(out_b),   32'(m_out_b));
    check("count",   32'(count),   32'(m_count));
  endtask

  // Drive one cycle of inputs (called just after a falling edge), then
  // compare everything on the next falling edge.
  task automatic cyc(input bit sv, input logic [3:0] a, input logic [7:0] b,
                     input bit st, input int kl);
    s_valid = sv; s_a = a; s_b = b; start = st; k_len = KW'(kl);
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 4'd0, 8'd0, 0, 0);
  endtask

  task automatic do_reset();
    s_valid = 0; start = 0; k_len = '0;
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    check("rst_no_done", 32'(done), 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; s_valid = 0; s_a = '0; s_b = '0; start = 0; k_len = '0;
    model_reset();
    @(negedge clk);
    compare_all();
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_count",   32'(count),   32'd0);
    reset = 1'b0;

    // Single pair, k_len = 1.
    cyc(1, 4'd3, 8'hFB, 0, 0);
    cyc(0, 4'd0, 8'd0, 1, 1);
    check("s1_busy", 32'(busy), 32'd1);
    cyc(0, 4'd0, 8'd0, 0, 0);
    check("s1_pulse", 32'(pulse), 32'd1);
    check("s1_out_a", 32'(out_a), 32'h3);
    check("s1_out_b", 32'(out_b), 32'hFB);
    check("s1_done",  32'(done),  32'd1);
    check("s1_count", 32'(count), 32'd1);
    check("s1_model_pulse", 32'(m_pulse), 32'd1);
    check("s1_model_out_b", 32'(m_out_b), 32'hFB);
    idle(1);
    check("s1_pulse_off", 32'(pulse), 32'd0);
    check("s1_done_off",  32'(done),  32'd0);
    check("s1_count_hold", 32'(count), 32'd1);

    // Fill the FIFO without starting, offer a fifth pair, then drain.
    for (int i = 1; i <= 4; i++) cyc(1, 4'(i), 8'(10*i), 0, 0);
    check("s2_full_ready", 32'(s_ready), 32'd0);
    cyc(1, 4'd7, 8'd77, 0, 0);
    check("s2_model_occ", 32'(q_a.size()), 32'd4);
    cyc(0, 4'd0, 8'd0, 1, 4);
    for (int i = 1; i <= 4; i++) begin
      cyc(0, 4'd0, 8'd0, 0, 0);
      check("s2_pulse", 32'(pulse), 32'd1);
      check("s2_out_a", 32'(out_a), 32'(i));
      check("s2_out_b", 32'(out_b), 32'(10*i));
    end
    check("s2_done", 32'(done), 32'd1);
    idle(1);

    // Zero-length run.
    cyc(0, 4'd0, 8'd0, 1, 0);
    check("s3_done",  32'(done),  32'd1);
    check("s3_pulse", 32'(pulse), 32'd0);
    check("s3_count", 32'(count), 32'd0);
    idle(1);
    check("s3_idle", 32'(busy), 32'd0);

    // k_len = 3 with pairs arriving every other cycle.
    cyc(0, 4'd0, 8'd0, 1, 3);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 4'(i + 5), 8'(8'h80 + i), 0, 0);
      check("s4_no_bypass", 32'(pulse), 32'd0);
      cyc(0, 4'd0, 8'd0, 0, 0);
      check("s4_pulse", 32'(pulse), 32'd1);
      check("s4_out_a", 32'(out_a), 32'(i + 5));
    end
    check("s4_done",  32'(done),  32'd1);
    check("s4_count", 32'(count), 32'd3);
    idle(1);

    // Reset in the middle of a five-pair run.
    cyc(1, 4'd1, 8'd1, 0, 0);
    cyc(1, 4'd2, 8'd2, 1, 5);
    cyc(1, 4'd3, 8'd3, 0, 0);
    cyc(0, 4'd0, 8'd0, 0, 0);
    check("s5_count2", 32'(count), 32'd2);
    do_reset();
    check("s5_pulse",   32'(pulse),   32'd0);
    check("s5_count",   32'(count),   32'd0);
    check("s5_s_ready", 32'(s_ready), 32'd1);
    check("s5_busy",    32'(busy),    32'd0);
    idle(2);
    check("s5_no_done", 32'(done), 32'd0);

`ifdef MAC_FEEDER_ZERO_SKIP_EN
    cyc(1, 4'd0, 8'd7, 0, 0);
    cyc(1, 4'd2, 8'hF8, 0, 0);
    cyc(0, 4'd0, 8'd0, 1, 2);
    cyc(0, 4'd0, 8'd0, 0, 0);
    check("s6_skip_pulse", 32'(pulse), 32'd0);
    check("s6_skip_count", 32'(count), 32'd1);
    cyc(0, 4'd0, 8'd0, 0, 0);
    check("s6_pulse", 32'(pulse), 32'd1);
    check("s6_out_a", 32'(out_a), 32'h2);
    check("s6_out_b", 32'(out_b), 32'hF8);
    check("s6_count", 32'(count), 32'd2);
    check("s6_done",  32'(done),  32'd1);
    idle(1);
`endif

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        cyc(($urandom_range(0, 9) < 6),
            4'($urandom_range(0, 15)) & (($urandom_range(0, 4) == 0) ? 4'h0 : 4'hF),
            8'($urandom),
            ($urandom_range(0, 4) == 0),
            int'($urandom_range(0, 6)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
